mul_repeated_add: RTL and testbench

- Sequential unsigned multiplier built as a datapath plus a controller FSM in one block.
- Operands arrive one after the other on a shared input bus: multiplicand first, then multiplier.
- The product is formed by adding the multiplicand into an accumulator once per multiplier count, while a down-counter decrements to zero.
- The block sits behind any simple sequencer that can pulse or hold `start` and present operands on consecutive cycles.

---
 rtl/mul_repeated_add_if.sv | 9 +
 rtl/mul_repeated_add.sv | 54 +++++
 tb/tb_mul_repeated_add.sv | 99 +++++++++
 3 files changed

// File: rtl/mul_repeated_add_if.sv
// mul_repeated_add_if: operand/result bus between a sequencer and the multiplier
interface mul_repeated_add_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] product;
  logic             done;
  modport master (output start, data_in, input product, done);
  modport slave  (input start, data_in, output product, done);
endinterface

// File: rtl/mul_repeated_add.sv
// mul_repeated_add: unsigned multiplier by repeated addition with a down-counting multiplier
module mul_repeated_add #(parameter int WIDTH = 16) (
  input logic               clk,
  input logic               rst_n,
  mul_repeated_add_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MUL, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic             eqz;
  assign eqz         = b_q == '0;
  assign bus.product = p_q;
  assign bus.done    = state_q == DONE;
  // next state and datapath updates; eqz is tested before any decrement so B never wraps
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    case (state_q)
      IDLE:    state_d = bus.start ? LOAD_A : IDLE;
      LOAD_A: begin
        a_d     = bus.data_in;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = bus.data_in;
        p_d     = '0;
        state_d = MUL;
      end
      MUL: begin
        state_d = eqz ? DONE : MUL;
        p_d     = eqz ? p_q : p_q + a_q;
        b_d     = eqz ? b_q : b_q - WIDTH'(1);
      end
      DONE:    state_d = bus.start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end
endmodule

// File: tb/tb_mul_repeated_add.sv
// tb_mul_repeated_add: directed checks of product value and done timing
module tb_mul_repeated_add;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  mul_repeated_add_if #(.WIDTH(16)) bus ();
  mul_repeated_add #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    bus.start = 1'b1;
    step();
    bus.data_in = a;
    step();
    bus.data_in = b;
    step();
    chk({tag, "_pclr"}, bus.product, 16'h0);
    for (int i = 0; i < int'(b); i++) begin
      bus.data_in = 16'($urandom);
      step();
    end
    chk({tag, "_not_early"}, 16'(bus.done), 16'h0);
    step();
    chk({tag, "_done"}, 16'(bus.done), 16'h1);
    chk({tag, "_prod"}, bus.product, exp);
  endtask
  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = 16'h0;
    step();
    step();
    chk("rst_prod", bus.product, 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    rst_n = 1'b1;
    step();
    run("m17x5", 16'd17, 16'd5, 16'd85);
    step();
    step();
    chk("hold_done", 16'(bus.done), 16'h1);
    chk("hold_prod", bus.product, 16'd85);
    bus.start = 1'b0;
    step();
    chk("idle_done", 16'(bus.done), 16'h0);
    run("m7x9", 16'd7, 16'd9, 16'd63);
    bus.start = 1'b0;
    step();
    run("m1234x0", 16'd1234, 16'd0, 16'd0);
    bus.start = 1'b0;
    step();
    run("ovf", 16'hFFFF, 16'd3, 16'hFFFD);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.data_in = 16'd100;
    step();
    bus.data_in = 16'd50;
    step();
    step();
    step();
    chk("mid_prod", bus.product, 16'd200);
    chk("mid_done", 16'(bus.done), 16'h0);
    rst_n = 1'b0;
    step();
    chk("abort_prod", bus.product, 16'h0);
    chk("abort_done", 16'(bus.done), 16'h0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    step();
    chk("abort_idle", 16'(bus.done), 16'h0);
    run("m3x4", 16'd3, 16'd4, 16'd12);
    bus.start = 1'b0;
    step();
    run("m0x10", 16'd0, 16'd10, 16'd0);
    bus.start = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
